mem_access_master: RTL and testbench

- Initiator side of the single-word memory bus (mem_addr / mem_read_en / mem_write_en / mem_write_val / mem_read_val / mem_response).
- Accepts one load or store at a time from the CPU datapath and converts the CPU byte address to a word index.
- Drives the bus until the memory responds or a timeout expires, then returns read data and status to the CPU.
- Sits between the CPU load/store stage and the temporary memory model.

---
 rtl/mem_access_master_pkg.sv | 14 +
 rtl/mem_timeout_counter.sv | 30 +++
 rtl/mem_access_master.sv | 117 +++++++++++
 tb/tb_mem_access_master.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_master_pkg.sv
// Shared definitions for the memory access master and the CPU load/store stage:
// FSM state encoding, byte-to-word shift and the default memory depth.
package mem_access_master_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_t;

  localparam int WORD_SHIFT        = 2;
  localparam int DEFAULT_MEM_WORDS = 256;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts ACCESS cycles without a memory response and flags the last allowed cycle.
module mem_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Saturates at the terminal value so the flag stays stable until cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !terminal) begin
      count <= count + CW'(1);
    end
  end

  assign terminal = (count == LAST);

endmodule

// File: rtl/mem_access_master.sv
// Single-word bus initiator: takes one CPU load/store, drives the memory bus
// until a response or timeout, then reports data and status back to the CPU.
module mem_access_master
  import mem_access_master_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_WORDS      = DEFAULT_MEM_WORDS,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_read_req,
  input  logic                  cpu_write_req,
  input  logic [DATA_WIDTH-1:0] cpu_write_data,
  output logic                  cpu_ready,
  output logic                  cpu_done,
  output logic                  cpu_error,
  output logic [DATA_WIDTH-1:0] cpu_read_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  output logic [DATA_WIDTH-1:0] mem_write_val,
  input  logic [DATA_WIDTH-1:0] mem_read_val,
  input  logic                  mem_response
);

  localparam logic [ADDR_WIDTH-1:0] WORD_LIMIT = ADDR_WIDTH'(MEM_WORDS);

  state_t                state;
  logic [ADDR_WIDTH-1:0] word_index;
  logic                  accept;
  logic                  illegal;
  logic                  timeout_hit;

  assign word_index = cpu_addr >> WORD_SHIFT;
  assign accept     = cpu_ready && (cpu_read_req || cpu_write_req);
  assign illegal    = (cpu_read_req && cpu_write_req) ||
                      (cpu_addr[1:0] != 2'b00) ||
                      (word_index >= WORD_LIMIT);

  mem_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state != ACCESS),
    .enable  ((state == ACCESS) && !mem_response),
    .terminal(timeout_hit)
  );

  // After an illegal request cpu_ready drops for the cpu_done cycle, so a
  // back-to-back illegal request cannot produce two consecutive done pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cpu_ready     <= 1'b1;
      cpu_done      <= 1'b0;
      cpu_error     <= 1'b0;
      cpu_read_data <= '0;
      mem_addr      <= '0;
      mem_read_en   <= 1'b0;
      mem_write_en  <= 1'b0;
      mem_write_val <= '0;
    end else begin
      cpu_done  <= 1'b0;
      cpu_error <= 1'b0;
      unique case (state)
        IDLE: begin
          cpu_ready <= 1'b1;
          if (accept) begin
            cpu_ready <= 1'b0;
            if (illegal) begin
              cpu_done  <= 1'b1;
              cpu_error <= 1'b1;
            end else begin
              mem_addr      <= word_index;
              mem_write_val <= cpu_write_data;
              mem_read_en   <= cpu_read_req;
              mem_write_en  <= cpu_write_req;
              state         <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (mem_response) begin
            if (mem_read_en) begin
              cpu_read_data <= mem_read_val;
            end
            cpu_done     <= 1'b1;
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
            state        <= RECOVER;
          end else if (timeout_hit) begin
            cpu_done     <= 1'b1;
            cpu_error    <= 1'b1;
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
            state        <= RECOVER;
          end
        end
        RECOVER: begin
          cpu_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          cpu_ready    <= 1'b1;
          mem_read_en  <= 1'b0;
          mem_write_en <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_master.sv
// Directed bench for mem_access_master with a small word memory and a
// responder that can answer immediately, stay silent, or be forced by hand.
module tb_mem_access_master;

  logic        clk;
  logic        rst_n;
  logic [31:0] cpu_addr;
  logic        cpu_read_req;
  logic        cpu_write_req;
  logic [31:0] cpu_write_data;
  logic        cpu_ready;
  logic        cpu_done;
  logic        cpu_error;
  logic [31:0] cpu_read_data;
  logic [31:0] mem_addr;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_write_val;
  logic [31:0] mem_read_val;
  logic        mem_response;

  logic        auto_resp;
  logic        force_resp;
  logic [31:0] mem [256];

  int compared;
  int mismatched;

  mem_access_master dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_addr      (cpu_addr),
    .cpu_read_req  (cpu_read_req),
    .cpu_write_req (cpu_write_req),
    .cpu_write_data(cpu_write_data),
    .cpu_ready     (cpu_ready),
    .cpu_done      (cpu_done),
    .cpu_error     (cpu_error),
    .cpu_read_data (cpu_read_data),
    .mem_addr      (mem_addr),
    .mem_read_en   (mem_read_en),
    .mem_write_en  (mem_write_en),
    .mem_write_val (mem_write_val),
    .mem_read_val  (mem_read_val),
    .mem_response  (mem_response)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model answers in the same cycle an enable is seen, unless silenced.
  assign mem_response = (auto_resp && (mem_read_en || mem_write_en)) || force_resp;
  assign mem_read_val = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_write_en && mem_response) mem[mem_addr[7:0]] = mem_write_val;
  end

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  logic [31:0] bad_addr [3];
  logic        bad_rd   [3];
  logic        bad_wr   [3];

  initial begin
    compared       = 0;
    mismatched     = 0;
    rst_n          = 1'b0;
    cpu_addr       = '0;
    cpu_read_req   = 1'b0;
    cpu_write_req  = 1'b0;
    cpu_write_data = '0;
    auto_resp      = 1'b1;
    force_resp     = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]   = 32'h0000_0001;
    mem[1]   = 32'h0000_0042;
    mem[2]   = 32'h0000_7777;
    mem[255] = 32'hA5A5_0FF0;

    // Reset values
    nextCycle();
    checkOutput("rst_ready", cpu_ready, 1);
    checkOutput("rst_done", cpu_done, 0);
    checkOutput("rst_error", cpu_error, 0);
    checkOutput("rst_rdata", cpu_read_data, 0);
    checkOutput("rst_addr", mem_addr, 0);
    checkOutput("rst_rd_en", mem_read_en, 0);
    checkOutput("rst_wr_en", mem_write_en, 0);
    checkOutput("rst_wval", mem_write_val, 0);
    rst_n = 1'b1;
    nextCycle();

    // Load from 0x00 at minimum latency
    cpu_addr = 32'h00; cpu_read_req = 1'b1;
    nextCycle();
    cpu_read_req = 1'b0;
    checkOutput("ld0_rd_en", mem_read_en, 1);
    checkOutput("ld0_wr_en", mem_write_en, 0);
    checkOutput("ld0_addr", mem_addr, 0);
    checkOutput("ld0_ready", cpu_ready, 0);
    checkOutput("ld0_done_early", cpu_done, 0);
    nextCycle();
    checkOutput("ld0_done", cpu_done, 1);
    checkOutput("ld0_error", cpu_error, 0);
    checkOutput("ld0_rdata", cpu_read_data, 32'h0000_0001);
    checkOutput("ld0_rd_en_off", mem_read_en, 0);
    nextCycle();
    checkOutput("ld0_done_once", cpu_done, 0);
    checkOutput("ld0_ready_back", cpu_ready, 1);

    // Store then load at 0x4C
    cpu_addr = 32'h4C; cpu_write_req = 1'b1; cpu_write_data = 32'hDEAD_BEEF;
    nextCycle();
    cpu_write_req = 1'b0;
    checkOutput("st_wr_en", mem_write_en, 1);
    checkOutput("st_rd_en", mem_read_en, 0);
    checkOutput("st_addr", mem_addr, 32'h13);
    checkOutput("st_wval", mem_write_val, 32'hDEAD_BEEF);
    nextCycle();
    checkOutput("st_done", cpu_done, 1);
    checkOutput("st_error", cpu_error, 0);
    checkOutput("st_gap_wr", mem_write_en, 0);
    cpu_read_req = 1'b1;
    nextCycle();
    checkOutput("gap_rd_en", mem_read_en, 0);
    checkOutput("gap_wr_en", mem_write_en, 0);
    checkOutput("gap_ready", cpu_ready, 1);
    checkOutput("gap_done", cpu_done, 0);
    nextCycle();
    cpu_read_req = 1'b0;
    checkOutput("ld4c_rd_en", mem_read_en, 1);
    checkOutput("ld4c_addr", mem_addr, 32'h13);
    nextCycle();
    checkOutput("ld4c_done", cpu_done, 1);
    checkOutput("ld4c_error", cpu_error, 0);
    checkOutput("ld4c_rdata", cpu_read_data, 32'hDEAD_BEEF);
    nextCycle();

    // Stray response while idle is ignored
    force_resp = 1'b1;
    nextCycle();
    force_resp = 1'b0;
    checkOutput("stray_done", cpu_done, 0);
    checkOutput("stray_ready", cpu_ready, 1);
    checkOutput("stray_rdata", cpu_read_data, 32'hDEAD_BEEF);

    // Highest legal word
    cpu_addr = 32'h3FC; cpu_read_req = 1'b1;
    nextCycle();
    cpu_read_req = 1'b0;
    checkOutput("top_addr", mem_addr, 32'hFF);
    checkOutput("top_rd_en", mem_read_en, 1);
    nextCycle();
    checkOutput("top_done", cpu_done, 1);
    checkOutput("top_error", cpu_error, 0);
    checkOutput("top_rdata", cpu_read_data, 32'hA5A5_0FF0);
    nextCycle();

    // Timeout with a silent responder
    auto_resp = 1'b0;
    cpu_addr = 32'h08; cpu_read_req = 1'b1;
    nextCycle();
    cpu_read_req = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      checkOutput($sformatf("to_wait%0d", i), {31'b0, mem_read_en && !cpu_done}, 1);
      nextCycle();
    end
    checkOutput("to_done", cpu_done, 1);
    checkOutput("to_error", cpu_error, 1);
    checkOutput("to_rdata", cpu_read_data, 32'hA5A5_0FF0);
    checkOutput("to_rd_en", mem_read_en, 0);
    nextCycle();
    checkOutput("to_done_once", cpu_done, 0);
    checkOutput("to_idle", cpu_ready, 1);

    // Illegal requests: both strobes, misaligned, out of range
    bad_addr[0] = 32'h00;  bad_rd[0] = 1'b1; bad_wr[0] = 1'b1;
    bad_addr[1] = 32'h41;  bad_rd[1] = 1'b1; bad_wr[1] = 1'b0;
    bad_addr[2] = 32'h400; bad_rd[2] = 1'b1; bad_wr[2] = 1'b0;
    auto_resp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cpu_addr = bad_addr[i]; cpu_read_req = bad_rd[i]; cpu_write_req = bad_wr[i];
      nextCycle();
      cpu_read_req = 1'b0; cpu_write_req = 1'b0;
      checkOutput($sformatf("ill%0d_done", i), cpu_done, 1);
      checkOutput($sformatf("ill%0d_error", i), cpu_error, 1);
      checkOutput($sformatf("ill%0d_en", i), {31'b0, mem_read_en || mem_write_en}, 0);
      nextCycle();
      checkOutput($sformatf("ill%0d_done_once", i), cpu_done, 0);
      checkOutput($sformatf("ill%0d_en_after", i), {31'b0, mem_read_en || mem_write_en}, 0);
      checkOutput($sformatf("ill%0d_ready", i), cpu_ready, 1);
    end

    // Reset in the second ACCESS cycle of a store
    auto_resp = 1'b0;
    cpu_addr = 32'h10; cpu_write_req = 1'b1; cpu_write_data = 32'h1234_5678;
    nextCycle();
    cpu_write_req = 1'b0;
    checkOutput("rs_wr_en1", mem_write_en, 1);
    nextCycle();
    checkOutput("rs_wr_en2", mem_write_en, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rs_wr_drop", mem_write_en, 0);
    checkOutput("rs_done", cpu_done, 0);
    nextCycle();
    rst_n = 1'b1;
    nextCycle();
    checkOutput("rs_ready", cpu_ready, 1);
    checkOutput("rs_done_after", cpu_done, 0);
    checkOutput("rs_wr_after", mem_write_en, 0);
    checkOutput("rs_mem", mem[4], 32'h0);

    // Response on the same edge as the terminal count wins
    cpu_addr = 32'h04; cpu_read_req = 1'b1;
    nextCycle();
    cpu_read_req = 1'b0;
    for (int i = 0; i < 15; i++) nextCycle();
    checkOutput("tc_still_busy", mem_read_en, 1);
    checkOutput("tc_no_done", cpu_done, 0);
    force_resp = 1'b1;
    nextCycle();
    force_resp = 1'b0;
    checkOutput("tc_done", cpu_done, 1);
    checkOutput("tc_error", cpu_error, 0);
    checkOutput("tc_rdata", cpu_read_data, 32'h0000_0042);
    nextCycle();
    checkOutput("tc_ready", cpu_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
